// File: rtl/interboard_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interboard_send_arbiter
// Purpose  : Round-robin arbiter that drains several show-ahead source FIFOs,
//            one bounded burst per grant, into the write side of the
//            send-board FIFO while honouring that FIFO's fill level.
// Ports    : clk_i           - system clock, all logic on rising edge
//            reset_i         - synchronous active-high reset
//            src_rdempty_i   - per-source FIFO empty flags
//            src_data_i      - per-source FIFO heads, source i at [i*DATA_W +: DATA_W]
//            src_rdreq_o     - per-source read acknowledge (combinational, one-hot/zero)
//            wrusedw_i       - send-board FIFO fill level
//            data_o          - word written to the send-board FIFO (registered)
//            wrreq_o         - send-board FIFO write strobe (registered)
//            grant_o         - one-hot current owner, zero when idle (registered)
//            busy_o          - high while a grant is held
// Config   : INTERBOARD_ARB_BURST_EN - defined: grants last up to BURST_MAX
//            words; undefined: every transfer ends the grant (per-word
//            round-robin) and the burst counter is not built.
// Revision : 1.0 - initial release
// ============================================================================
module interboard_send_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int DATA_W      = 11,
  parameter int USEDW_W     = 8,
  parameter int FULL_THRESH = 252,
  parameter int BURST_MAX   = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_SRC-1:0]        src_rdempty_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  output logic [NUM_SRC-1:0]        src_rdreq_o,
  input  logic [USEDW_W-1:0]        wrusedw_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      wrreq_o,
  output logic [NUM_SRC-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [USEDW_W-1:0] FULL_THRESH_W = USEDW_W'(FULL_THRESH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    last_q;
  logic [NUM_SRC-1:0]  grant_q;
  logic [DATA_W-1:0]   data_q;
  logic                wrreq_q;

  logic                w_full;
  logic                w_xfer;
  logic                w_owner_empty;
  logic                w_last_beat;
  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [NUM_SRC-1:0]  w_sel_onehot;
  logic [DATA_W-1:0]   w_owner_data;

  // Source index reached by stepping ofs places past base, wrapping at NUM_SRC.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int               ofs);
    wrap_idx = IDX_W'((int'(base) + ofs) % NUM_SRC);
  endfunction

  // Full is a plain unsigned compare; the threshold leaves room for the
  // write pipeline and the lag of wrusedw behind actual writes.
  assign w_full        = (wrusedw_i >= FULL_THRESH_W);
  assign w_owner_empty = src_rdempty_i[owner_q];
  assign w_owner_data  = src_data_i[int'(owner_q)*DATA_W +: DATA_W];
  assign w_xfer        = (state_q == ST_GRANT) && !w_owner_empty && !w_full;

  // Round-robin scan starting just after the last owner. Walking the offsets
  // from the far end backwards lets the nearest non-empty source win.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (!src_rdempty_i[wrap_idx(last_q, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(last_q, k);
      end
    end
  end

  assign w_sel_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << w_sel;

  // The acknowledge is the only combinational output: it must accompany the
  // show-ahead head word in the same cycle the word is captured.
  always_comb begin
    src_rdreq_o = '0;
    if (w_xfer) begin
      src_rdreq_o[owner_q] = 1'b1;
    end
  end

`ifdef INTERBOARD_ARB_BURST_EN
  logic [7:0] burst_cnt_q;
  assign w_last_beat = (burst_cnt_q == 8'(BURST_MAX - 1));
`else
  // A grant never carries more than one word in this build.
  localparam int BURST_LIM = (BURST_MAX < 1) ? BURST_MAX : 1;
  assign w_last_beat = (BURST_LIM <= 1);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);   // source 0 is first after reset
      grant_q <= '0;
      data_q  <= '0;
      wrreq_q <= 1'b0;
`ifdef INTERBOARD_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Arbitration cycle: no word moves, and full does not block it.
          wrreq_q <= 1'b0;
          if (w_found) begin
            state_q <= ST_GRANT;
            owner_q <= w_sel;
            grant_q <= w_sel_onehot;
`ifdef INTERBOARD_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
          end
        end

        ST_GRANT: begin
          wrreq_q <= w_xfer;
          if (w_xfer) begin
            data_q <= w_owner_data;
`ifdef INTERBOARD_ARB_BURST_EN
            burst_cnt_q <= burst_cnt_q + 8'd1;
`endif
            if (w_last_beat) begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              last_q  <= owner_q;
`ifdef INTERBOARD_ARB_BURST_EN
              burst_cnt_q <= '0;
`endif
            end
          end else if (w_owner_empty) begin
            // Empty owner gives up the link; full with data pending holds it.
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
`ifdef INTERBOARD_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
          end
        end

        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          wrreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_o  = data_q;
  assign wrreq_o = wrreq_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_interboard_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_interboard_send_arbiter
// Purpose  : Directed self-checking bench for interboard_send_arbiter with
//            two counter-backed show-ahead source FIFOs. Source s word n is
//            {s, n[7:0]}, so order, loss and duplication are all visible.
//            Expected tables follow INTERBOARD_ARB_BURST_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interboard_send_arbiter;

  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 11;
  localparam int USEDW_W = 8;
`ifdef INTERBOARD_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_SRC-1:0]        src_rdempty;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_rdreq;
  logic [USEDW_W-1:0]        wrusedw = '0;
  logic [DATA_W-1:0]         data;
  logic                      wrreq;
  logic [NUM_SRC-1:0]        grant;
  logic                      busy;

  int total = 0;
  int bad   = 0;
  int cyc;
  int head [NUM_SRC];
  int lim  [NUM_SRC];

  int          lg_cyc [$];
  logic [10:0] lg_dat [$];
  int          ex_cyc [$];
  logic [10:0] ex_dat [$];

  always #5 clk = ~clk;

  interboard_send_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .DATA_W      (DATA_W),
    .USEDW_W     (USEDW_W),
    .FULL_THRESH (252),
    .BURST_MAX   (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .src_rdempty_i (src_rdempty),
    .src_data_i    (src_data),
    .src_rdreq_o   (src_rdreq),
    .wrusedw_i     (wrusedw),
    .data_o        (data),
    .wrreq_o       (wrreq),
    .grant_o       (grant),
    .busy_o        (busy)
  );

  function automatic logic [10:0] mkword(input int s, input int n);
    mkword = 11'((s << 8) | (n & 255));
  endfunction

  // Show-ahead source FIFOs: head counter walks up to a per-test limit.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_rdempty[i]                 = (head[i] >= lim[i]);
    assign src_data[i*DATA_W +: DATA_W]   = mkword(i, head[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset)             head[i] <= 0;
      else if (src_rdreq[i]) head[i] <= head[i] + 1;
    end
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Log every write with the edge number it appeared after; check the
  // acknowledge is one-hot-or-zero and only ever for the owner.
  always @(negedge clk) begin
    if (!reset && wrreq) begin
      lg_cyc.push_back(cyc);
      lg_dat.push_back(data);
    end
    check("rdreq_owner", 32'(($onehot0(src_rdreq)) && ((src_rdreq & ~grant) == '0)), 32'd1);
  end

  task automatic add_exp(input int c, input int s, input int n);
    ex_cyc.push_back(c);
    ex_dat.push_back(mkword(s, n));
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_count"}, 32'(lg_cyc.size()), 32'(ex_cyc.size()));
    n = (lg_cyc.size() < ex_cyc.size()) ? lg_cyc.size() : ex_cyc.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_cyc"},  32'(lg_cyc[i]), 32'(ex_cyc[i]));
      check({tag, "_data"}, 32'(lg_dat[i]), 32'(ex_dat[i]));
    end
  endtask

  // Hold reset for 3 edges (checking outputs), release at the negedge after
  // the last reset edge. The next posedge is edge 1 of the test.
  task automatic start_test(input int l0, input int l1);
    reset   = 1'b1;
    wrusedw = '0;
    lim[0]  = l0;
    lim[1]  = l1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_wrreq", 32'(wrreq), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_rdreq", 32'(src_rdreq), 32'd0);
      check("rst_data",  32'(data),  32'd0);
    end
    reset = 1'b0;
    lg_cyc.delete(); lg_dat.delete();
    ex_cyc.delete(); ex_dat.delete();
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    lim[0] = 0;
    lim[1] = 0;

    // Reset, first grant, then rotation with 20 words per source.
    start_test(20, 20);
    run(1);
    check("first_grant", 32'(grant), 32'd1);
    check("first_busy",  32'(busy),  32'd1);
    check("first_wrreq", 32'(wrreq), 32'd0);
`ifdef INTERBOARD_ARB_BURST_EN
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) add_exp(2 + 9*b + k, b % 2, (b/2)*8 + k);
    for (int k = 0; k < 4; k++) add_exp(38 + k, 0, 16 + k);
    for (int k = 0; k < 4; k++) add_exp(44 + k, 1, 16 + k);
`else
    for (int j = 0; j < 40; j++) add_exp(2 + 2*j, j % 2, j / 2);
`endif
    run(BURST ? 49 : 81);
    #1;
    compare_log("rotate");

    // Early release when the owner runs dry.
    start_test(3, 10);
`ifdef INTERBOARD_ARB_BURST_EN
    for (int k = 0; k < 3; k++) add_exp(2 + k, 0, k);
    for (int k = 0; k < 8; k++) add_exp(7 + k, 1, k);
    add_exp(16, 1, 8);
    add_exp(17, 1, 9);
`else
    add_exp(2, 0, 0); add_exp(4, 1, 0);
    add_exp(6, 0, 1); add_exp(8, 1, 1);
    add_exp(10, 0, 2); add_exp(12, 1, 2);
    for (int m = 0; m < 7; m++) add_exp(14 + 2*m, 1, 3 + m);
`endif
    run(BURST ? 20 : 30);
    #1;
    compare_log("empty");

    // Backpressure: full for 10 cycles starting after edge 4.
    start_test(20, 20);
    run(4);
    wrusedw = 8'd252;
    #1;
    check("bp_rdreq", 32'(src_rdreq), 32'd0);
    for (int k = 5; k <= 13; k++) begin
      @(negedge clk);
      check("bp_rdreq", 32'(src_rdreq), 32'd0);
      check("bp_grant", 32'(grant), 32'd1);
    end
    @(negedge clk);
    wrusedw = 8'd251;
    #1;
    check("bp_resume", 32'(src_rdreq), 32'd1);
`ifdef INTERBOARD_ARB_BURST_EN
    for (int k = 0; k < 3; k++) add_exp(2 + k, 0, k);
    for (int k = 0; k < 5; k++) add_exp(15 + k, 0, 3 + k);
    for (int k = 0; k < 8; k++) add_exp(21 + k, 1, k);
`else
    add_exp(2, 0, 0);
    add_exp(4, 1, 0);
    for (int m = 0; m < 7; m++) add_exp(15 + 2*m, m % 2, 1 + m/2);
`endif
    run(14);
    #1;
    compare_log("bp");

    // Reset on the 4th transfer cycle, then source 0 must win again.
    start_test(20, 20);
    run(BURST ? 4 : 7);
    check("mid_rdreq", 32'(src_rdreq), BURST ? 32'd1 : 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_wrreq", 32'(wrreq), 32'd0);
    check("mid_grant", 32'(grant), 32'd0);
    check("mid_busy",  32'(busy),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_grant", 32'(grant), 32'd1);
    @(negedge clk);
    check("rel_wrreq", 32'(wrreq), 32'd1);
    check("rel_data",  32'(data),  32'(mkword(0, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
